// File: rtl/hdc_pkg.sv
// Shared HDC associative-memory constants, score/class types and the argmax FSM encoding.
// Used by the tree adder, the controller and the class argmax tracker.
package hdc_pkg;

  localparam int NUM_CLASSES = 26;
  localparam int SIM_W       = 13;
  localparam int CLASS_W     = $clog2(NUM_CLASSES);
  localparam int COUNT_W     = $clog2(NUM_CLASSES + 1);

  typedef logic [SIM_W-1:0]   sim_t;
  typedef logic [CLASS_W-1:0] class_t;
  typedef logic [COUNT_W-1:0] count_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } argmax_state_e;

  function automatic logic class_in_range(input class_t cls);
    return cls < class_t'(NUM_CLASSES);
  endfunction

endpackage

// File: rtl/am_top2_update.sv
// Combinational top-2 tracker step: folds one new (score, class) beat into the
// current best / best_class / second, keeping the earlier class on ties.
module am_top2_update
  import hdc_pkg::*;
(
  input  logic   first,
  input  sim_t   best,
  input  class_t best_class,
  input  sim_t   second,
  input  sim_t   value,
  input  class_t cls,
  output sim_t   best_next,
  output class_t best_class_next,
  output sim_t   second_next
);

  always_comb begin
    best_next       = best;
    best_class_next = best_class;
    second_next     = second;
    // The first beat claims best even at score 0 so best_class names a class actually seen.
    if (first) begin
      best_next       = value;
      best_class_next = cls;
    end else if (value > best) begin
      second_next     = best;
      best_next       = value;
      best_class_next = cls;
    end else if (value > second) begin
      second_next     = value;
    end
  end

endmodule

// File: rtl/am_class_argmax.sv
// Scans one similarity score per class and reports the winning class, its score
// and the margin over the runner-up; flags protocol violations in a sticky err.
module am_class_argmax
  import hdc_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               sim_valid,
  input  logic [SIM_W-1:0]   sim_value,
  input  logic [CLASS_W-1:0] sim_class,
  input  logic               sim_last,
  output logic               busy,
  output logic               done,
  output logic               result_valid,
  output logic [CLASS_W-1:0] best_class,
  output logic [SIM_W-1:0]   best_score,
  output logic [SIM_W-1:0]   margin,
  output logic               err
);

  argmax_state_e state_reg, state_next;

  sim_t   best_reg, second_reg, margin_reg;
  class_t best_class_reg;
  count_t count_reg;
  logic   err_reg, done_reg;

  logic   clear, accept, err_set, enter_done;
  sim_t   best_upd, second_upd;
  class_t best_class_upd;

  am_top2_update u_top2 (
    .first           (count_reg == '0),
    .best            (best_reg),
    .best_class      (best_class_reg),
    .second          (second_reg),
    .value           (sim_value),
    .cls             (sim_class),
    .best_next       (best_upd),
    .best_class_next (best_class_upd),
    .second_next     (second_upd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    clear      = 1'b0;
    accept     = 1'b0;
    err_set    = 1'b0;
    enter_done = 1'b0;
    // start overrides everything, including a beat presented in the same cycle.
    if (start) begin
      state_next = SCAN;
      clear      = 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          err_set = sim_valid;
        end
        SCAN: begin
          if (sim_valid) begin
            if (class_in_range(sim_class)) begin
              accept = 1'b1;
            end else begin
              err_set = 1'b1;
            end
            if (sim_last) begin
              state_next = DONE;
              enter_done = 1'b1;
              // count+1 != NUM_CLASSES; count saturates at NUM_CLASSES so no wrap.
              if (count_reg != count_t'(NUM_CLASSES - 1)) begin
                err_set = 1'b1;
              end
            end
          end
        end
        DONE: begin
          err_set = sim_valid;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_reg       <= '0;
      best_class_reg <= '0;
      second_reg     <= '0;
      margin_reg     <= '0;
      count_reg      <= '0;
      err_reg        <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      done_reg <= enter_done;
      if (clear) begin
        best_reg       <= '0;
        best_class_reg <= '0;
        second_reg     <= '0;
        margin_reg     <= '0;
        count_reg      <= '0;
        err_reg        <= 1'b0;
      end else begin
        if (accept) begin
          best_reg       <= best_upd;
          best_class_reg <= best_class_upd;
          second_reg     <= second_upd;
          margin_reg     <= best_upd - second_upd;
          if (count_reg != count_t'(NUM_CLASSES)) begin
            count_reg <= count_reg + 1'b1;
          end
        end
        if (err_set) begin
          err_reg <= 1'b1;
        end
      end
    end
  end

  assign busy         = (state_reg == SCAN);
  assign result_valid = (state_reg == DONE);
  assign done         = done_reg;
  assign best_class   = best_class_reg;
  assign best_score   = best_reg;
  assign margin       = margin_reg;
  assign err          = err_reg;

endmodule
